// File: rtl/div_pipe.sv
// div_pipe: fully pipelined unsigned restoring divider.
// One quotient bit is resolved per stage, MSB first, across WIDTH_A stages.
// A single advance signal moves or holds the whole pipeline, bubbles included,
// so a stalled output freezes every stage in place.
module div_pipe #(
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 8,
    parameter int TAG_W   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_A-1:0] numerator,
    input  logic [WIDTH_B-1:0] denominator,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_A-1:0] quotient,
    output logic [WIDTH_B-1:0] remainder,
    output logic               div_zero,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int LAST = WIDTH_A - 1;

    // Per-stage state. nq holds the numerator bits still to be consumed in its
    // upper part and the quotient bits resolved so far shifted in from the
    // bottom; after the last stage it is the full quotient. The denominator is
    // not needed once the last step has been taken, so it stops one stage early.
    logic [WIDTH_A-1:0] valid_q, valid_d;
    logic [WIDTH_A-1:0] zero_q, zero_d;
    logic [WIDTH_B-1:0] rem_q [WIDTH_A];
    logic [WIDTH_B-1:0] rem_d [WIDTH_A];
    logic [WIDTH_A-1:0] nq_q  [WIDTH_A];
    logic [WIDTH_A-1:0] nq_d  [WIDTH_A];
    logic [TAG_W-1:0]   tag_q [WIDTH_A];
    logic [TAG_W-1:0]   tag_d [WIDTH_A];
    logic [WIDTH_B-1:0] den_q [LAST];
    logic [WIDTH_B-1:0] den_d [LAST];

    // What each stage sees on its input side (stage 0 is fed by the ports).
    logic [WIDTH_A-1:0] src_valid, src_zero;
    logic [WIDTH_B-1:0] src_rem [WIDTH_A];
    logic [WIDTH_A-1:0] src_nq  [WIDTH_A];
    logic [WIDTH_B-1:0] src_den [WIDTH_A];
    logic [TAG_W-1:0]   src_tag [WIDTH_A];
    logic [WIDTH_B:0]   step    [WIDTH_A];
    logic               advance;

    // One restoring step: returns {quotient bit, new partial remainder}.
    // When the subtraction happens the true result is below the denominator,
    // so it fits in WIDTH_B bits and the low-bit subtraction is exact. With a
    // zero denominator the compare always succeeds and the remainder simply
    // shifts the numerator through, leaving its low WIDTH_B bits at the end.
    function automatic logic [WIDTH_B:0] div_step(
        input logic [WIDTH_B-1:0] rem,
        input logic               nbit,
        input logic [WIDTH_B-1:0] den
    );
        logic [WIDTH_B:0] trial;
        logic             ge;
        trial = {rem, nbit};
        ge    = (trial >= {1'b0, den});
        if (ge) begin
            div_step = {1'b1, trial[WIDTH_B-1:0] - den};
        end else begin
            div_step = {1'b0, trial[WIDTH_B-1:0]};
        end
    endfunction

    assign advance  = !valid_q[LAST] || out_ready;
    assign in_ready = advance;

    // Route ports into stage 0 and each stage's register into the next stage.
    always_comb begin
        src_valid[0] = in_valid;
        src_zero[0]  = (denominator == '0);
        src_rem[0]   = '0;
        src_nq[0]    = numerator;
        src_den[0]   = denominator;
        src_tag[0]   = in_tag;
        for (int k = 1; k < WIDTH_A; k++) begin
            src_valid[k] = valid_q[k-1];
            src_zero[k]  = zero_q[k-1];
            src_rem[k]   = rem_q[k-1];
            src_nq[k]    = nq_q[k-1];
            src_den[k]   = den_q[k-1];
            src_tag[k]   = tag_q[k-1];
        end
    end

    // Division step for every stage, MSB of the remaining numerator first.
    always_comb begin
        for (int k = 0; k < WIDTH_A; k++) begin
            step[k] = div_step(src_rem[k], src_nq[k][WIDTH_A-1], src_den[k]);
        end
    end

    // Next state: shift every stage by one place on advance, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        zero_d  = zero_q;
        rem_d   = rem_q;
        nq_d    = nq_q;
        tag_d   = tag_q;
        den_d   = den_q;
        if (advance) begin
            valid_d = src_valid;
            zero_d  = src_zero;
            for (int k = 0; k < WIDTH_A; k++) begin
                rem_d[k] = step[k][WIDTH_B-1:0];
                nq_d[k]  = {src_nq[k][WIDTH_A-2:0], step[k][WIDTH_B]};
                tag_d[k] = src_tag[k];
            end
            for (int k = 0; k < LAST; k++) begin
                den_d[k] = src_den[k];
            end
        end
    end

    // Pipeline registers; reset clears valids and data so outputs read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            zero_q  <= '0;
            for (int k = 0; k < WIDTH_A; k++) begin
                rem_q[k] <= '0;
                nq_q[k]  <= '0;
                tag_q[k] <= '0;
            end
            for (int k = 0; k < LAST; k++) begin
                den_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            zero_q  <= zero_d;
            rem_q   <= rem_d;
            nq_q    <= nq_d;
            tag_q   <= tag_d;
            den_q   <= den_d;
        end
    end

    assign out_valid = valid_q[LAST];
    assign quotient  = nq_q[LAST];
    assign remainder = rem_q[LAST];
    assign div_zero  = valid_q[LAST] & zero_q[LAST];
    assign out_tag   = tag_q[LAST];

endmodule

// File: tb/tb_div_pipe.sv
// tb_div_pipe: scoreboard bench for div_pipe at the default size plus two
// additional parameter sets driven with random traffic.
module tb_div_pipe;
    localparam int WA = 16;
    localparam int WB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    logic          rst, in_valid, in_ready, out_valid, out_ready, div_zero;
    logic [WA-1:0] numerator, quotient;
    logic [WB-1:0] denominator, remainder;
    logic [0:0]    in_tag, out_tag;

    div_pipe #(.WIDTH_A(WA), .WIDTH_B(WB), .TAG_W(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .numerator(numerator), .denominator(denominator), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_zero(div_zero), .out_tag(out_tag)
    );

    // Scoreboard for the main instance.
    logic [WA-1:0] sq_q[$];
    logic [WB-1:0] sq_r[$];
    logic          sq_z[$];
    logic          sq_t[$];
    int            sq_c[$];
    bit            sq_l[$];
    bit            lat_on    = 1'b0;
    bit            bp_mode   = 1'b0;
    int            force_req = 0;

    task automatic expect_op(input logic [WA-1:0] n, input logic [WB-1:0] d,
                             input logic t, input int acc);
        int ni, di;
        ni = int'(n);
        di = int'(d);
        if (di == 0) begin
            sq_q.push_back({WA{1'b1}});
            sq_r.push_back(n[WB-1:0]);
            sq_z.push_back(1'b1);
        end else begin
            sq_q.push_back(WA'(ni / di));
            sq_r.push_back(WB'(ni % di));
            sq_z.push_back(1'b0);
        end
        sq_t.push_back(t);
        sq_c.push_back(acc);
        sq_l.push_back(lat_on);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [WA-1:0] n, input logic [WB-1:0] d,
                        input logic t, input bit must_be_ready);
        int waited;
        waited      = 0;
        in_valid    = 1'b1;
        numerator   = n;
        denominator = d;
        in_tag      = t;
        @(negedge clk);
        if (must_be_ready) chk("in_ready_no_stall", in_ready, 1);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready) expect_op(n, d, t, cyc + 1);
        else chk("send_timeout", waited, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int w;
        w = 0;
        while (sq_q.size() != 0 && w < budget) begin
            @(negedge clk);
            w++;
        end
        chk("drain_all_results", sq_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // Output-side ready: always 1, random in backpressure mode, and a forced
    // 5-cycle low window once requested and a result is being presented.
    initial begin
        int seen, low;
        seen = 0;
        low  = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (force_req != seen && out_valid) begin
                seen = force_req;
                low  = 5;
            end
            if (low > 0) begin
                out_ready = 1'b0;
                low--;
            end else begin
                out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Monitor: compares every output transfer against the scoreboard head.
    initial begin
        logic [WA-1:0] pq;
        logic [WB-1:0] pr;
        logic          pz, pt;
        bit            pstall;
        int            c;
        bit            l;
        pstall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pstall = 1'b0;
            end else begin
                if (pstall) begin
                    chk("stall_hold_valid", out_valid, 1);
                    chk("stall_hold_data", {quotient, remainder, div_zero, out_tag},
                        {pq, pr, pz, pt});
                end
                if (!out_valid) chk("idle_div_zero", div_zero, 0);
                if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
                if (out_valid && out_ready) begin
                    chk("result_expected", sq_q.size() != 0, 1);
                    if (sq_q.size() != 0) begin
                        chk("quotient", quotient, sq_q.pop_front());
                        chk("remainder", remainder, sq_r.pop_front());
                        chk("div_zero", div_zero, sq_z.pop_front());
                        chk("out_tag", out_tag, sq_t.pop_front());
                        c = sq_c.pop_front();
                        l = sq_l.pop_front();
                        if (l) chk("latency", cyc - c + 1, WA);
                    end
                end
                pstall = out_valid && !out_ready;
                pq = quotient;
                pr = remainder;
                pz = div_zero;
                pt = out_tag;
            end
        end
    end

    // Parameter sweep instances: 1000 random ops each, first half without
    // backpressure (latency checked), second half with random out_ready.
    for (genvar g = 0; g < 2; g++) begin : sweep
        localparam int SA = (g == 0) ? 8 : 12;
        localparam int SB = (g == 0) ? 8 : 4;
        logic          srst, iv, ir, ov, ordy, dz;
        logic [SA-1:0] n, qo;
        logic [SB-1:0] d, ro;
        logic [3:0]    ti, to;
        logic [SA-1:0] eq[$];
        logic [SB-1:0] er[$];
        logic          ez[$];
        logic [3:0]    et[$];
        int            ec[$];
        bit            el[$];
        bit            done = 1'b0;

        div_pipe #(.WIDTH_A(SA), .WIDTH_B(SB), .TAG_W(4)) u_dut (
            .clk(clk), .rst(srst),
            .in_valid(iv), .in_ready(ir),
            .numerator(n), .denominator(d), .in_tag(ti),
            .out_valid(ov), .out_ready(ordy),
            .quotient(qo), .remainder(ro),
            .div_zero(dz), .out_tag(to)
        );

        initial begin
            int  sent, guard, ni, di;
            bit  phase, acc;
            sent  = 0;
            guard = 0;
            phase = 1'b0;
            srst = 1'b1; iv = 1'b0; n = '0; d = '0; ti = '0; ordy = 1'b1;
            repeat (3) @(posedge clk);
            #1 srst = 1'b0;
            while (!(sent == 1000 && eq.size() == 0) && guard < 20000) begin
                @(negedge clk);
                acc = iv && ir;
                if (acc) begin
                    ni = int'(n);
                    di = int'(d);
                    if (di == 0) begin
                        eq.push_back({SA{1'b1}});
                        er.push_back(n[SB-1:0]);
                        ez.push_back(1'b1);
                    end else begin
                        eq.push_back(SA'(ni / di));
                        er.push_back(SB'(ni % di));
                        ez.push_back(1'b0);
                    end
                    et.push_back(ti);
                    ec.push_back(cyc + 1);
                    el.push_back(!phase);
                    sent++;
                end
                @(posedge clk); #1;
                if (acc) iv = 1'b0;
                if (!phase && sent == 500 && eq.size() == 0) phase = 1'b1;
                if (!iv && sent < 1000 && !(!phase && sent >= 500) &&
                    $urandom_range(0, 3) != 0) begin
                    n  = SA'($urandom);
                    d  = ($urandom_range(0, 15) == 0) ? '0 : SB'($urandom);
                    ti = 4'($urandom);
                    iv = 1'b1;
                end
                ordy = phase ? 1'($urandom_range(0, 1)) : 1'b1;
                guard++;
            end
            chk("sweep_ops_accepted", sent, 1000);
            chk("sweep_drained", eq.size(), 0);
            done = 1'b1;
        end

        initial begin
            int c;
            bit l;
            forever begin
                @(negedge clk);
                if (!srst) begin
                    if (!ov) chk("sw_idle_div_zero", dz, 0);
                    if (ov && ordy) begin
                        chk("sw_result_expected", eq.size() != 0, 1);
                        if (eq.size() != 0) begin
                            chk("sw_quotient", qo, eq.pop_front());
                            chk("sw_remainder", ro, er.pop_front());
                            chk("sw_div_zero", dz, ez.pop_front());
                            chk("sw_out_tag", to, et.pop_front());
                            c = ec.pop_front();
                            l = el.pop_front();
                            if (l) chk("sw_latency", cyc - c + 1, SA);
                        end
                    end
                end
            end
        end
    end

    // Main directed and random sequence.
    initial begin
        int w;
        rst = 1'b1; in_valid = 1'b0; numerator = '0; denominator = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_div_zero", div_zero, 0);
        chk("reset_out_tag", out_tag, 0);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // single op with full latency
        lat_on = 1'b1;
        send(16'd1000, 8'd7, 1'b1, 1'b1);
        drain(40);

        // boundary values back to back
        send(16'd65535, 8'd255, 1'b0, 1'b1);
        send(16'd5, 8'd9, 1'b1, 1'b1);
        send(16'd65535, 8'd1, 1'b0, 1'b1);
        send(16'd0, 8'd3, 1'b1, 1'b1);
        drain(40);

        // divide by zero followed by a normal op
        send(16'h1234, 8'd0, 1'b1, 1'b1);
        send(16'd100, 8'd10, 1'b0, 1'b1);
        drain(40);

        // backpressure with random traffic
        lat_on  = 1'b0;
        bp_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 6) force_req++;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send(WA'($urandom), WB'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        end
        drain(400);
        bp_mode = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end

        // reset mid-stream discards everything in flight
        for (int i = 0; i < 6; i++) begin
            send(WA'($urandom), WB'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), 1'b1);
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        sq_q.delete(); sq_r.delete(); sq_z.delete();
        sq_t.delete(); sq_c.delete(); sq_l.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            chk("flushed_no_output", out_valid, 0);
        end
        @(posedge clk); #1;
        lat_on = 1'b1;
        send(16'd77, 8'd8, 1'b0, 1'b1);
        drain(40);

        w = 0;
        while (!(sweep[0].done && sweep[1].done) && w < 40000) begin
            @(posedge clk);
            w++;
        end
        chk("sweeps_finished", sweep[0].done && sweep[1].done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
